// File: rtl/usb_bulk_in_arb_if.sv
// Byte-wide AXI4-Stream link between a bulk-IN source, the arbiter and the protocol core.
// The master drives valid/data/last and the slave drives ready.
interface usb_bulk_in_arb_if;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic [7:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/usb_bulk_in_arb.sv
// Grants EP1/EP2 bulk-IN source to the core for one packet per IN token; zero-latency mux gated by registered grant.
// Backpressure: m tready reaches only the granted source. USB_BULK_MAXPKT_EN forces tlast at MAX_PACKET bytes.
module usb_bulk_in_arb #(
    parameter logic [3:0]  EP1_ADDR   = 4'd1,
    parameter logic [3:0]  EP2_ADDR   = 4'd2,
    parameter int unsigned MAX_PACKET = 512
) (
    input  logic                     clock,
    input  logic                     areset_n,
    input  logic                     blk_start_i,
    input  logic [3:0]               blk_endpt_i,
    input  logic                     blk_error_i,
    input  logic                     ep1_ready_i,
    input  logic                     ep2_ready_i,
    output logic                     blk_in_ready_o,
    usb_bulk_in_arb_if.slave         s1_axis,
    usb_bulk_in_arb_if.slave         s2_axis,
    usb_bulk_in_arb_if.master        m_axis,
    output logic [1:0]               grant_o,
    output logic                     done_o,
    output logic [3:0]               done_ep_o,
    output logic                     abort_o
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [9:0] MAX_CNT = 10'(MAX_PACKET);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [9:0] cnt_q, cnt_d;
    logic [3:0] done_ep_q, done_ep_d;
    logic       abort_q, abort_d;

    logic       hit_ep1, hit_ep2;
    logic [1:0] gnt;
    logic       src_last;
    logic       hs;
    logic       pkt_end;
    logic [3:0] sel_ep;

    assign hit_ep1        = (blk_endpt_i == EP1_ADDR);
    assign hit_ep2        = (blk_endpt_i == EP2_ADDR);
    assign blk_in_ready_o = (hit_ep1 & ep1_ready_i) | (hit_ep2 & ep2_ready_i);
    assign sel_ep         = sel_q[0] ? EP1_ADDR : EP2_ADDR;

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= IDLE;
            sel_q     <= 2'b00;
            cnt_q     <= 10'd0;
            done_ep_q <= 4'd0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            done_ep_q <= done_ep_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        done_ep_d = done_ep_q;
        abort_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Source 1 is checked first so it wins when both addresses coincide.
                if (blk_start_i && hit_ep1) begin
                    state_d = XFER;
                    sel_d   = 2'b01;
                    cnt_d   = 10'd0;
                end else if (blk_start_i && hit_ep2) begin
                    state_d = XFER;
                    sel_d   = 2'b10;
                    cnt_d   = 10'd0;
                end
            end
            XFER: begin
                if (hs && (cnt_q != MAX_CNT)) begin
                    cnt_d = cnt_q + 10'd1;
                end
                // An error in the same cycle as the final byte still aborts the packet.
                if (blk_error_i) begin
                    state_d   = IDLE;
                    abort_d   = 1'b1;
                    done_ep_d = sel_ep;
                end else if (pkt_end) begin
                    state_d   = DONE;
                    done_ep_d = sel_ep;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt            = 2'b00;
        done_o         = 1'b0;
        m_axis.tvalid  = 1'b0;
        m_axis.tdata   = 8'h00;
        src_last       = 1'b0;
        s1_axis.tready = 1'b0;
        s2_axis.tready = 1'b0;
        if (state_q == XFER) begin
            gnt = sel_q;
        end
        if (state_q == DONE) begin
            done_o = 1'b1;
        end
        if (gnt[0]) begin
            m_axis.tvalid  = s1_axis.tvalid;
            m_axis.tdata   = s1_axis.tdata;
            src_last       = s1_axis.tlast;
            s1_axis.tready = m_axis.tready;
        end else if (gnt[1]) begin
            m_axis.tvalid  = s2_axis.tvalid;
            m_axis.tdata   = s2_axis.tdata;
            src_last       = s2_axis.tlast;
            s2_axis.tready = m_axis.tready;
        end
    end

`ifdef USB_BULK_MAXPKT_EN
    // The byte that brings the count to MAX_PACKET closes the packet; the source never sees this tlast.
    assign m_axis.tlast = src_last | ((gnt != 2'b00) && (cnt_q == (MAX_CNT - 10'd1)));
`else
    assign m_axis.tlast = src_last;
`endif

    assign hs        = m_axis.tvalid & m_axis.tready;
    assign pkt_end   = hs & m_axis.tlast;
    assign grant_o   = gnt;
    assign done_ep_o = done_ep_q;
    assign abort_o   = abort_q;

endmodule

// File: tb/tb_usb_bulk_in_arb.sv
// Bench for usb_bulk_in_arb: queue-based sources and a packet-level reference model.
`timescale 1ns/1ps
module tb_usb_bulk_in_arb;
    localparam logic [3:0] EP1  = 4'd1;
    localparam logic [3:0] EP2  = 4'd2;
    localparam int         MAXP = 8;

    logic       clock = 1'b0;
    logic       areset_n = 1'b0;
    logic       blk_start, blk_error, ep1_ready, ep2_ready, blk_in_ready, done, abort;
    logic [3:0] blk_endpt, done_ep;
    logic [1:0] grant;

    usb_bulk_in_arb_if s1();
    usb_bulk_in_arb_if s2();
    usb_bulk_in_arb_if m();

    usb_bulk_in_arb #(.EP1_ADDR(EP1), .EP2_ADDR(EP2), .MAX_PACKET(MAXP)) dut (
        .clock(clock), .areset_n(areset_n), .blk_start_i(blk_start), .blk_endpt_i(blk_endpt),
        .blk_error_i(blk_error), .ep1_ready_i(ep1_ready), .ep2_ready_i(ep2_ready),
        .blk_in_ready_o(blk_in_ready), .s1_axis(s1), .s2_axis(s2), .m_axis(m),
        .grant_o(grant), .done_o(done), .done_ep_o(done_ep), .abort_o(abort));

    always #5 clock = ~clock;

    int total = 0, bad = 0, cyc = 0;
    logic [8:0] q1[$], q2[$], outq[$], expq[$];
    logic       k_start = 0, k_err = 0, k_mrdy = 0, k_gap = 0, k_rovr = 0, k_r1 = 0, k_r2 = 0;
    logic [3:0] k_endpt = 0;
    logic       o_mv, o_ml, o_s1r, o_s2r, o_done, o_abort, o_bir, o_hs;
    logic [7:0] o_md;
    logic [1:0] o_grant, first_grant;
    logic [3:0] o_dep, dep_seen;
    int         grant_cnt, done_cnt, abort_cnt, last_hs, done_cyc, leak;
    logic       timeout;

    // One clock: drive at posedge+1, sample at negedge, source queues pop on observed handshakes.
    task automatic tick();
        blk_start = k_start; blk_endpt = k_endpt; blk_error = k_err; m.tready = k_mrdy;
        s1.tvalid = (q1.size() > 0) && !(k_gap && $urandom_range(0, 3) == 0);
        s2.tvalid = (q2.size() > 0) && !(k_gap && $urandom_range(0, 3) == 0);
        if (q1.size() > 0) begin s1.tdata = q1[0][7:0]; s1.tlast = q1[0][8]; end
        else begin s1.tdata = 8'h00; s1.tlast = 1'b0; end
        if (q2.size() > 0) begin s2.tdata = q2[0][7:0]; s2.tlast = q2[0][8]; end
        else begin s2.tdata = 8'h00; s2.tlast = 1'b0; end
        ep1_ready = k_rovr ? k_r1 : (q1.size() > 0);
        ep2_ready = k_rovr ? k_r2 : (q2.size() > 0);
        @(negedge clock);
        o_mv = m.tvalid; o_ml = m.tlast; o_md = m.tdata; o_s1r = s1.tready; o_s2r = s2.tready;
        o_grant = grant; o_done = done; o_abort = abort; o_dep = done_ep; o_bir = blk_in_ready;
        o_hs = m.tvalid && m.tready;
        if (s1.tvalid && s1.tready) q1.delete(0);
        if (s2.tvalid && s2.tready) q2.delete(0);
        @(posedge clock); #1;
        cyc++;
    endtask

    task automatic push_pkt(input int src, input int len, input int base);
        logic [8:0] e;
        for (int i = 0; i < len; i++) begin
            e[7:0] = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
            e[8]   = (i == len - 1);
            if (src == 1) q1.push_back(e); else q2.push_back(e);
        end
    endtask

    // Reference: next packet = source bytes up to its tlast, cut at MAXP when truncation is built in.
    function automatic void build_exp(input int src);
        logic [8:0] e;
        int n;
        expq.delete();
        n = (src == 1) ? q1.size() : q2.size();
        for (int i = 0; i < n; i++) begin
            e = (src == 1) ? q1[i] : q2[i];
`ifdef USB_BULK_MAXPKT_EN
            if (expq.size() == MAXP - 1) e[8] = 1'b1;
`endif
            expq.push_back(e);
            if (e[8]) break;
        end
    endfunction

    function automatic int pkt_diff();
        if (outq.size() != expq.size()) return -2;
        foreach (outq[i]) if (outq[i] !== expq[i]) return i;
        return -1;
    endfunction

    task automatic token(input logic [3:0] ep);
        k_start = 1'b1; k_endpt = ep; tick(); k_start = 1'b0;
    endtask

    // Runs cycles until done, abort, or just after an injected error; records what was seen.
    task automatic xfer(input int mode, input int err_at);
        int n;
        n = 0; outq.delete(); grant_cnt = 0; done_cnt = 0; abort_cnt = 0; leak = 0;
        last_hs = -1; done_cyc = -1; dep_seen = 4'hx; timeout = 1'b1; first_grant = 2'b00;
        for (int c = 0; c < 400; c++) begin
            case (mode)
                0:       k_mrdy = 1'b1;
                1:       k_mrdy = (c[0] == 1'b0);
                default: k_mrdy = 1'($urandom_range(0, 1));
            endcase
            k_err = (err_at >= 0) && (n == err_at);
            tick();
            if (c == 0) first_grant = o_grant;
            if (o_grant != 2'b00) grant_cnt++;
            if ((o_s1r && o_grant != 2'b01) || (o_s2r && o_grant != 2'b10)) leak++;
            if (o_hs) begin outq.push_back({o_ml, o_md}); n++; last_hs = cyc; end
            if (o_done) begin done_cnt++; done_cyc = cyc; dep_seen = o_dep; timeout = 1'b0; break; end
            if (o_abort) begin abort_cnt++; timeout = 1'b0; break; end
            if (k_err) begin timeout = 1'b0; break; end
        end
        k_err = 1'b0; k_mrdy = 1'b1;
    endtask

    task automatic test_reset();
        push_pkt(1, 2, 'h01); push_pkt(2, 2, 'h05); k_mrdy = 1'b1;
        tick();
        total++; if (o_grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%0h want=0", o_grant); end
        total++; if ({o_done, o_abort} !== 2'b00) begin bad++; $display("FAIL rst_done_abort got=%b want=00", {o_done, o_abort}); end
        total++; if (o_dep !== 4'd0) begin bad++; $display("FAIL rst_done_ep got=%0h want=0", o_dep); end
        total++; if ({o_mv, o_ml, o_md} !== 10'd0) begin bad++; $display("FAIL rst_m got=%0h want=0", {o_mv, o_ml, o_md}); end
        total++; if ({o_s1r, o_s2r} !== 2'b00) begin bad++; $display("FAIL rst_src_ready got=%b want=00", {o_s1r, o_s2r}); end
        areset_n = 1'b1;
        tick();
        total++; if ({o_grant, o_mv, o_s1r, o_s2r} !== 5'd0) begin bad++; $display("FAIL idle_no_token got=%b want=0", {o_grant, o_mv, o_s1r, o_s2r}); end
        q1.delete(); q2.delete();
    endtask

    task automatic test_basic();
        push_pkt(1, 4, 'h11); build_exp(1);
        token(EP1);
        total++; if (o_grant !== 2'b00) begin bad++; $display("FAIL basic_token_cycle_grant got=%0h want=0", o_grant); end
        xfer(0, -1);
        total++; if (pkt_diff() !== -1) begin bad++; $display("FAIL basic_data diff=%0d got_n=%0d want_n=%0d", pkt_diff(), outq.size(), expq.size()); end
        total++; if (first_grant !== 2'b01) begin bad++; $display("FAIL basic_grant_next got=%0h want=1", first_grant); end
        total++; if (grant_cnt !== 4) begin bad++; $display("FAIL basic_grant_cycles got=%0d want=4", grant_cnt); end
        total++; if (done_cnt !== 1 || done_cyc !== last_hs + 1) begin bad++; $display("FAIL basic_done got=%0d@%0d want=1@%0d", done_cnt, done_cyc, last_hs + 1); end
        total++; if (dep_seen !== EP1) begin bad++; $display("FAIL basic_done_ep got=%0h want=%0h", dep_seen, EP1); end
        total++; if (leak !== 0 || timeout !== 1'b0) begin bad++; $display("FAIL basic_leak_timeout got=%0d/%b want=0/0", leak, timeout); end
    endtask

    task automatic test_back_to_back_ep2();
        int n1;
        push_pkt(1, 3, 'h21); push_pkt(2, 5, 'h31); build_exp(2); n1 = q1.size();
        token(EP2);
        xfer(0, -1);
        total++; if (first_grant !== 2'b10) begin bad++; $display("FAIL b2b_grant got=%0h want=2", first_grant); end
        total++; if (pkt_diff() !== -1) begin bad++; $display("FAIL ep2_data diff=%0d got_n=%0d want_n=%0d", pkt_diff(), outq.size(), expq.size()); end
        total++; if (leak !== 0 || q1.size() !== n1) begin bad++; $display("FAIL ep2_s1_untouched got=%0d/%0d want=0/%0d", leak, q1.size(), n1); end
        total++; if (dep_seen !== EP2 || done_cnt !== 1) begin bad++; $display("FAIL ep2_done got=%0h/%0d want=%0h/1", dep_seen, done_cnt, EP2); end
        build_exp(1);
        token(EP1);
        xfer(2, -1);
        total++; if (pkt_diff() !== -1 || dep_seen !== EP1) begin bad++; $display("FAIL ep1_drain diff=%0d ep=%0h want=-1/%0h", pkt_diff(), dep_seen, EP1); end
    endtask

    task automatic test_bad_ep();
        int g, d, n1;
        logic exp_rdy;
        push_pkt(1, 2, 'h91); n1 = q1.size(); g = 0; d = 0;
        token(4'd3);
        if (o_grant != 2'b00) g++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (o_grant != 2'b00) g++;
            if (o_done) d++;
        end
        total++; if (g !== 0 || d !== 0 || q1.size() !== n1) begin bad++; $display("FAIL ep3_ignored got=g%0d d%0d n%0d want=0 0 %0d", g, d, q1.size(), n1); end
        k_rovr = 1'b1; k_endpt = 4'd3; k_r1 = 1'b1; k_r2 = 1'b1;
        tick();
        total++; if (o_bir !== 1'b0) begin bad++; $display("FAIL ep3_in_ready got=%b want=0", o_bir); end
        for (int i = 0; i < 12; i++) begin
            k_endpt = 4'($urandom_range(0, 3)); k_r1 = 1'($urandom_range(0, 1)); k_r2 = 1'($urandom_range(0, 1));
            exp_rdy = (k_endpt == EP1 && k_r1) || (k_endpt == EP2 && k_r2);
            tick();
            total++; if (o_bir !== exp_rdy) begin bad++; $display("FAIL in_ready ep=%0d r=%b%b got=%b want=%b", k_endpt, k_r2, k_r1, o_bir, exp_rdy); end
        end
        k_rovr = 1'b0;
        build_exp(1); token(EP1); xfer(0, -1);
        total++; if (pkt_diff() !== -1) begin bad++; $display("FAIL ep3_then_ep1 diff=%0d", pkt_diff()); end
    endtask

    task automatic test_maxpkt();
        int left;
`ifdef USB_BULK_MAXPKT_EN
        left = 2;
`else
        left = 0;
`endif
        push_pkt(1, 10, 'h40); build_exp(1);
        token(EP1); xfer(0, -1);
        total++; if (pkt_diff() !== -1) begin bad++; $display("FAIL maxpkt_first diff=%0d got_n=%0d want_n=%0d", pkt_diff(), outq.size(), expq.size()); end
        total++; if (q1.size() !== left || done_cnt !== 1) begin bad++; $display("FAIL maxpkt_left got=%0d/%0d want=%0d/1", q1.size(), done_cnt, left); end
`ifdef USB_BULK_MAXPKT_EN
        build_exp(1);
        token(EP1); xfer(0, -1);
        total++; if (pkt_diff() !== -1 || outq.size() !== 2) begin bad++; $display("FAIL maxpkt_second diff=%0d got_n=%0d want_n=2", pkt_diff(), outq.size()); end
`endif
    endtask

    task automatic test_abort();
        push_pkt(1, 6, 'h51); build_exp(1);
        while (expq.size() > 3) void'(expq.pop_back());
        token(EP1); xfer(0, 2);
        total++; if (pkt_diff() !== -1 || done_cnt !== 0) begin bad++; $display("FAIL abort_bytes diff=%0d done=%0d want=-1/0", pkt_diff(), done_cnt); end
        build_exp(1);
        token(EP1);
        total++; if ({o_abort, o_done, o_grant} !== 4'b1000) begin bad++; $display("FAIL abort_pulse got=%b want=1000", {o_abort, o_done, o_grant}); end
        total++; if (o_dep !== EP1) begin bad++; $display("FAIL abort_done_ep got=%0h want=%0h", o_dep, EP1); end
        xfer(0, -1);
        total++; if (first_grant !== 2'b01 || abort_cnt !== 0) begin bad++; $display("FAIL abort_retoken got=%0h/%0d want=1/0", first_grant, abort_cnt); end
        total++; if (pkt_diff() !== -1 || done_cnt !== 1) begin bad++; $display("FAIL abort_rest diff=%0d done=%0d", pkt_diff(), done_cnt); end
        push_pkt(2, 3, 'h61);
        token(EP2); xfer(0, 2);
        tick();
        total++; if ({o_abort, o_done} !== 2'b10 || o_dep !== EP2) begin bad++; $display("FAIL err_vs_tlast got=%b ep=%0h want=10 ep=%0h", {o_abort, o_done}, o_dep, EP2); end
        tick();
        total++; if ({o_abort, o_done} !== 2'b00) begin bad++; $display("FAIL err_vs_tlast_after got=%b want=00", {o_abort, o_done}); end
    endtask

    task automatic test_toggle();
        push_pkt(1, 5, 'h71); build_exp(1);
        token(EP1); xfer(1, -1);
        total++; if (pkt_diff() !== -1 || outq.size() !== 5) begin bad++; $display("FAIL toggle_data diff=%0d n=%0d want_n=5", pkt_diff(), outq.size()); end
        total++; if (done_cyc !== last_hs + 1 || grant_cnt !== 9) begin bad++; $display("FAIL toggle_timing done=%0d grant=%0d want=%0d/9", done_cyc, grant_cnt, last_hs + 1); end
    endtask

    task automatic test_async_reset();
        push_pkt(1, 6, 'h81);
        token(EP1); k_mrdy = 1'b1; tick(); tick();
        #2 areset_n = 1'b0; #1;
        total++; if ({grant, m.tvalid, m.tlast, m.tdata, s1.tready, s2.tready} !== 14'd0) begin bad++; $display("FAIL async_rst_path got=%0h want=0", {grant, m.tvalid, m.tlast, m.tdata, s1.tready, s2.tready}); end
        total++; if ({done, abort, done_ep} !== 6'd0) begin bad++; $display("FAIL async_rst_status got=%0h want=0", {done, abort, done_ep}); end
        @(posedge clock); #1;
        areset_n = 1'b1; q1.delete();
        push_pkt(2, 2, 'hA1); build_exp(2);
        token(EP2); xfer(0, -1);
        total++; if (pkt_diff() !== -1 || dep_seen !== EP2) begin bad++; $display("FAIL after_rst diff=%0d ep=%0h", pkt_diff(), dep_seen); end
    endtask

    task automatic test_random();
        int src;
        k_gap = 1'b1;
        for (int i = 0; i < 14; i++) begin
            src = $urandom_range(1, 2);
            push_pkt(src, $urandom_range(1, 12), -1);
            build_exp(src);
            token(src == 1 ? EP1 : EP2);
            xfer($urandom_range(0, 2), -1);
            total++; if (pkt_diff() !== -1) begin bad++; $display("FAIL rand_data[%0d] diff=%0d got_n=%0d want_n=%0d", i, pkt_diff(), outq.size(), expq.size()); end
            total++; if (done_cnt !== 1 || leak !== 0 || dep_seen !== (src == 1 ? EP1 : EP2)) begin bad++; $display("FAIL rand_done[%0d] got=%0d/%0d/%0h want=1/0/%0d", i, done_cnt, leak, dep_seen, src); end
        end
        k_gap = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        blk_start = 0; blk_endpt = 0; blk_error = 0; ep1_ready = 0; ep2_ready = 0;
        m.tready = 0; s1.tvalid = 0; s1.tlast = 0; s1.tdata = 0; s2.tvalid = 0; s2.tlast = 0; s2.tdata = 0;
        @(posedge clock); #1;
        test_reset();
        test_basic();
        test_back_to_back_ep2();
        test_bad_ep();
        test_maxpkt();
        test_abort();
        test_toggle();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
